// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared constants and helpers for the byte-oriented UART pair
//   (uart_byte_rx / uart_byte_tx).
//   - Baud codes as presented on the 3-bit baud_set port.
//   - Frame geometry for 16x oversampling with a 7-sample majority window.
//   - baud_rate()/baud_div(): elaboration-time divisor computation.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Baud select codes; anything above BAUD_115200 falls back to 9600.
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Frame geometry (in oversample ticks within one bit).
    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_FIRST = 6;
    localparam int SAMPLE_LAST  = 12;
    localparam int EVAL_TICK    = 13;
    localparam int FRAME_BITS   = 10;
    localparam int START_BIT    = 0;
    localparam int STOP_BIT     = FRAME_BITS - 1;

    // Flops between the raw pin and the first usable sample.
    localparam int SYNC_STAGES  = 2;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RECV = 1'b1
    } rx_state_e;

    function automatic int unsigned baud_rate(input logic [2:0] code);
        int unsigned rate;
        case (code)
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            default:     rate = 9600;
        endcase
        return rate;
    endfunction

    // Clock cycles per oversample tick.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input logic [2:0]  code);
        return clk_freq / (baud_rate(code) * int'(OVERSAMPLE));
    endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_edge
//   Brings the asynchronous serial line into the Clk domain through a
//   two-flop synchronizer and adds one further flop so a falling edge
//   (previous sample high, current sample low) can be detected.
//   Ports:
//     Clk        system clock
//     Rst        asynchronous active-high reset (all flops go to 1 = idle line)
//     rx_i       raw serial line
//     rx_sync_o  synchronized line level
//     fall_o     high for one cycle on a synchronized high-to-low transition
// ---------------------------------------------------------------------------
module uart_rx_sync_edge
    import uart_pkg::*;
(
    input  logic Clk,
    input  logic Rst,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_o
);

    localparam int CHAIN_W = SYNC_STAGES + 1;

    // chain_q[0] is the metastability catcher, chain_q[CHAIN_W-2] is the
    // synchronized level, chain_q[CHAIN_W-1] is the previous level.
    logic [CHAIN_W-1:0] chain_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[CHAIN_W-2:0], rx_i};
        end
    end

    assign rx_sync_o = chain_q[CHAIN_W-2];
    assign fall_o    = chain_q[CHAIN_W-1] & ~chain_q[CHAIN_W-2];

endmodule

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
//   8N1 serial receiver with 16x oversampling and a 7-of-16 majority vote
//   per bit. One byte per frame; good frames pulse Rx_Done, frames whose stop
//   bit votes low pulse Frame_Err instead.
//   Parameters:
//     CLK_FREQ    system clock frequency in Hz
//   Ports:
//     Clk         system clock
//     Rst         asynchronous active-high reset
//     baud_set    rate select (0=9600 .. 4=115200, 5-7 = 9600), latched per frame
//     Rs232_Rx    serial line, idles high
//     data_byte   last correctly received byte
//     Rx_Done     one-cycle pulse when data_byte was updated
//     Frame_Err   one-cycle pulse when the stop bit votes low
//     uart_state  high while a frame is being received
// ---------------------------------------------------------------------------
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
)
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       Rx_Done,
    output logic       Frame_Err,
    output logic       uart_state
);

    // The slowest rate has the largest divisor and sets the counter width.
    localparam int unsigned DIV_SLOWEST = baud_div(CLK_FREQ, BAUD_9600);
    localparam int          DIV_W       = $clog2(DIV_SLOWEST + 1);

    // -----------------------------------------------------------------------
    // Line conditioning
    // -----------------------------------------------------------------------
    logic rx_sync;
    logic start_edge;

    uart_rx_sync_edge u_sync_edge (
        .Clk       (Clk),
        .Rst       (Rst),
        .rx_i      (Rs232_Rx),
        .rx_sync_o (rx_sync),
        .fall_o    (start_edge)
    );

    // -----------------------------------------------------------------------
    // Terminal-count table, one entry per baud code, fixed at elaboration.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_last_tbl [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_div_tbl
        localparam int unsigned DIV_G = baud_div(CLK_FREQ, 3'(gi));
        assign div_last_tbl[gi] = DIV_W'(DIV_G - 1);
    end

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    rx_state_e        state_q,   state_d;
    logic [2:0]       baud_q,    baud_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]       bps_cnt_q, bps_cnt_d;
    logic [2:0]       vote_q,    vote_d;
    logic [7:0]       shadow_q,  shadow_d;
    logic [7:0]       data_q,    data_d;
    logic             done_q,    done_d;
    logic             ferr_q,    ferr_d;

    // -----------------------------------------------------------------------
    // Tick generator and bit-position decode
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_last;
    logic             tick;
    logic [3:0]       phase;      // tick number within the current bit
    logic [3:0]       bit_idx;    // 0 = start, 1..8 = data, 9 = stop
    logic             in_window;
    logic             eval;
    logic             bit_val;
    logic             frame_end;

    assign div_last  = div_last_tbl[baud_q];
    assign tick      = (state_q == RX_RECV) && (div_cnt_q == div_last);
    assign phase     = bps_cnt_q[3:0];
    assign bit_idx   = bps_cnt_q[7:4];
    assign in_window = tick && (phase >= 4'(SAMPLE_FIRST)) && (phase <= 4'(SAMPLE_LAST));
    assign eval      = tick && (phase == 4'(EVAL_TICK));
    // Majority of the seven window samples.
    assign bit_val   = (vote_q >= 3'd4);

    // A frame ends early on a false start, or at the middle of the stop bit
    // so that a start bit following with no idle gap is still seen as an edge.
    assign frame_end = eval && (((bit_idx == 4'(START_BIT)) && bit_val) ||
                                (bit_idx == 4'(STOP_BIT)));

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE: if (start_edge) state_d = RX_RECV;
            RX_RECV: if (frame_end)  state_d = RX_IDLE;
            default: state_d = RX_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        baud_d    = baud_q;
        div_cnt_d = div_cnt_q;
        bps_cnt_d = bps_cnt_q;
        vote_d    = vote_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            RX_IDLE: begin
                // Divider is parked so the first tick lands DIV cycles after the edge.
                div_cnt_d = '0;
                if (start_edge) begin
                    baud_d    = baud_set;
                    bps_cnt_d = '0;
                    vote_d    = '0;
                end
            end

            RX_RECV: begin
                if (tick) begin
                    div_cnt_d = '0;
                    bps_cnt_d = bps_cnt_q + 8'd1;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end

                if (in_window) begin
                    vote_d = vote_q + {2'b00, rx_sync};
                end

                if (eval) begin
                    vote_d = '0;
                    if (bit_idx == 4'(STOP_BIT)) begin
                        if (bit_val) begin
                            data_d = shadow_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else if (bit_idx != 4'(START_BIT)) begin
                        // LSB arrives first, so shift in from the top.
                        shadow_d = {bit_val, shadow_q[7:1]};
                    end
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            baud_q    <= '0;
            div_cnt_q <= '0;
            bps_cnt_q <= '0;
            vote_q    <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            baud_q    <= baud_d;
            div_cnt_q <= div_cnt_d;
            bps_cnt_q <= bps_cnt_d;
            vote_q    <= vote_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
        end
    end

    assign data_byte  = data_q;
    assign Rx_Done    = done_q;
    assign Frame_Err  = ferr_q;
    assign uart_state = (state_q == RX_RECV);

endmodule

// File: tb/tb_uart_byte_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_byte_rx
//   Drives 8N1 frames onto the serial line from a behavioural transmitter
//   and checks every Rx_Done / Frame_Err pulse against a queue of expected
//   events filled when each frame is launched. A reduced CLK_FREQ keeps the
//   divisors small (24, 12, 6, 4, 2) so every baud code fits a short run.
// ---------------------------------------------------------------------------
module tb_uart_byte_rx;

    localparam int unsigned CLK_FREQ = 3_686_400;
    localparam int          CLK_HALF = 5;
    localparam int          CLK_PER  = 2 * CLK_HALF;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [2:0] baud_set = 3'd0;
    logic       Rs232_Rx = 1'b1;
    logic [7:0] data_byte;
    logic       Rx_Done;
    logic       Frame_Err;
    logic       uart_state;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .baud_set   (baud_set),
        .Rs232_Rx   (Rs232_Rx),
        .data_byte  (data_byte),
        .Rx_Done    (Rx_Done),
        .Frame_Err  (Frame_Err),
        .uart_state (uart_state)
    );

    always #CLK_HALF Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard state ----------------
    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_exp = 0, err_exp = 0;
    int         done_seen = 0, err_seen = 0;
    logic [7:0] last_good = 8'h00;

    // Cycles per oversample tick for a baud code, from the rate table.
    function automatic int div_of(input int code);
        int rates [5] = '{9600, 19200, 38400, 57600, 115200};
        int rate;
        rate = (code >= 0 && code <= 4) ? rates[code] : 9600;
        return int'(CLK_FREQ) / (rate * 16);
    endfunction

    function automatic int bp_of(input int code, input real factor);
        return $rtoi(real'(div_of(code) * 16 * CLK_PER) * factor + 0.5);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    // ---------------- monitor ----------------
    always begin : monitor
        exp_t e;
        @(negedge Clk);
        if (!Rst && (Rx_Done || Frame_Err)) begin
            if (Rx_Done)   done_seen++;
            if (Frame_Err) err_seen++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b data=%02h cyc=%0d, none expected",
                         Rx_Done, Frame_Err, data_byte, cyc);
            end else begin
                e = exp_q.pop_front();
                if ((Rx_Done && Frame_Err) || (Rx_Done == e.is_err) ||
                    (data_byte != e.data) || (cyc < e.lo) || (cyc > e.hi)) begin
                    n_bad++;
                    $display("FAIL rx_event: done=%0b err=%0b data=%02h cyc=%0d, need %s data=%02h cyc %0d..%0d",
                             Rx_Done, Frame_Err, data_byte, cyc,
                             e.is_err ? "frame_err" : "rx_done", e.data, e.lo, e.hi);
                end else begin
                    $display("rx %s data=%02h cyc=%0d", e.is_err ? "frame_err" : "rx_done",
                             data_byte, cyc);
                end
            end
        end
    end

    // ---------------- behavioural transmitter ----------------
    task automatic send_frame(input int code, input logic [7:0] b, input real factor,
                              input bit stop_val, input bit expect_out, input bit align);
        int   d, bp;
        exp_t e;
        d  = div_of(code);
        bp = bp_of(code, factor);
        baud_set = 3'(code);
        if (align) @(negedge Clk);
        if (expect_out) begin
            e.is_err = !stop_val;
            e.data   = stop_val ? b : last_good;
            e.lo     = cyc + 158 * d;
            e.hi     = cyc + 158 * d + 4;
            exp_q.push_back(e);
            if (stop_val) begin
                last_good = b;
                done_exp++;
            end else begin
                err_exp++;
            end
        end
        Rs232_Rx = 1'b0;
        #(bp);
        // Rate select must be ignored once the frame has started.
        baud_set = 3'($urandom_range(0, 7));
        for (int i = 0; i < 8; i++) begin
            Rs232_Rx = b[i];
            if (i == 3) begin
                #(bp / 2);
                check("busy_mid_frame", int'(uart_state), 1);
                #(bp - bp / 2);
            end else begin
                #(bp);
            end
        end
        Rs232_Rx = stop_val;
        #(bp);
    endtask

    task automatic settle(input int cycles);
        repeat (cycles) @(negedge Clk);
        check("pending_events", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);
        check("err_count", err_seen, err_exp);
        check("idle_state", int'(uart_state), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bp, d, n, gap;
        logic [7:0] b;

        // Reset: outputs must clear without waiting for a clock edge.
        #2 Rst = 1'b1;
        #1;
        check("reset_data", int'(data_byte), 0);
        check("reset_done", int'(Rx_Done), 0);
        check("reset_ferr", int'(Frame_Err), 0);
        check("reset_state", int'(uart_state), 0);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (5) @(negedge Clk);

        // 0x55 at 9600, nominal.
        send_frame(0, 8'h55, 1.0, 1'b1, 1'b1, 1'b1);
        settle(20);
        check("data_55", int'(data_byte), 8'h55);

        // 0xA3 at 115200, transmitter 3% slow then 3% fast.
        send_frame(4, 8'hA3, 1.03, 1'b1, 1'b1, 1'b1);
        #(bp_of(4, 1.0));
        send_frame(4, 8'hA3, 0.97, 1'b1, 1'b1, 1'b1);
        settle(40);
        check("data_a3", int'(data_byte), 8'hA3);

        // Low glitch of 3/16 bit on an idle line at 9600: false start.
        d  = div_of(0);
        bp = bp_of(0, 1.0);
        baud_set = 3'd0;
        @(negedge Clk);
        Rs232_Rx = 1'b0;
        #(bp * 3 / 16);
        Rs232_Rx = 1'b1;
        repeat (2 * d) @(negedge Clk);
        check("glitch_busy", int'(uart_state), 1);
        repeat (12 * d + 6) @(negedge Clk);
        check("glitch_abort", int'(uart_state), 0);
        settle(4 * d);

        // Good 0x81 then 0x3C with a low stop bit, followed by a 5-bit break.
        send_frame(2, 8'h81, 1.0, 1'b1, 1'b1, 1'b1);
        send_frame(2, 8'h3C, 1.0, 1'b0, 1'b1, 1'b1);
        #(5 * bp_of(2, 1.0));
        Rs232_Rx = 1'b1;
        settle(40);
        check("data_after_ferr", int'(data_byte), 8'h81);

        // Back-to-back 0x00 then 0xFF at 115200, no idle between frames.
        send_frame(4, 8'h00, 1.0, 1'b1, 1'b1, 1'b1);
        send_frame(4, 8'hFF, 1.0, 1'b1, 1'b1, 1'b0);
        settle(20);
        check("data_b2b", int'(data_byte), 8'hFF);

        // Reset at data bit 4, then a clean 0x7E.
        bp = bp_of(3, 1.0);
        fork
            send_frame(3, 8'($urandom_range(0, 255)), 1.0, 1'b1, 1'b0, 1'b1);
            begin
                @(negedge Clk);
                #(5 * bp + 3);
                Rst = 1'b1;
                #1;
                check("midreset_data", int'(data_byte), 0);
                check("midreset_done", int'(Rx_Done), 0);
                check("midreset_ferr", int'(Frame_Err), 0);
                check("midreset_state", int'(uart_state), 0);
            end
        join
        #(bp);
        @(negedge Clk);
        Rst = 1'b0;
        last_good = 8'h00;
        repeat (5) @(negedge Clk);
        send_frame(3, 8'h7E, 1.0, 1'b1, 1'b1, 1'b1);
        settle(20);
        check("data_7e", int'(data_byte), 8'h7E);

        // Loopback-style traffic on every baud code with random bytes/gaps.
        for (int code = 0; code < 8; code++) begin
            n = (code >= 1 && code <= 4) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                b   = 8'($urandom_range(0, 255));
                send_frame(code, b, 1.0, 1'b1, 1'b1, 1'b1);
                gap = $urandom_range(0, 2) * bp_of(code, 1.0) / 2;
                if (gap > 0) #(gap);
            end
            settle(10);
        end

        // Byte sweep at 115200: extremes plus random values.
        send_frame(4, 8'h00, 1.0, 1'b1, 1'b1, 1'b1);
        send_frame(4, 8'hFF, 1.0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(4, b, 1.0, 1'b1, 1'b1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) #(bp_of(4, 1.0));
        end
        settle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(400_000 * CLK_PER);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
